kernel_row_sequencer: RTL and testbench
=======================================

# kernel_row_sequencer

Sequencer that walks the 11x11 Gaussian kernel ROM row by row and streams each 88-bit row to the convolution datapath over a valid/ready handshake. It owns the ROM's `rd_en`/`addr` port and absorbs the ROM's 1-cycle read latency. When the downstream side accepts every cycle, it sustains one row per cycle. It sits between the frame-level filter control, which issues `start`, and the window multiply-accumulate stage, which consumes the rows.

## Interface
- `ROWS`, default 11: number of kernel rows sequenced per pass (1..127).
- `AW`, default 7: ROM address width.
- `DW`, default 88: row width; a multiple of 8, one byte per weight.
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a pass; ignored unless the block is IDLE.
- `abort` in 1: terminates a pass in progress; `done` is not pulsed.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last row is accepted.
- `rom_rd_en` out 1: read enable to the kernel ROM.
- `rom_addr` out AW: ROM row address.
- `rom_data` in DW: ROM data; registered, valid one cycle after the `rom_rd_en` edge, and held while `rom_rd_en` is low.
- `row_valid` out 1: `row_data` is valid.
- `row_ready` in 1: downstream accepts the row.
- `row_data` out DW: current kernel row, passed through from `rom_data`.
- `row_idx` out 7: index of the current row.
- `row_last` out 1: high with `row_valid` when `row_idx == ROWS-1`.
- `kernel_sum` out 16: sum of all weights in the pass. Present only with `KSEQ_SUM_EN`.

## Operation
- FSM states: IDLE, FETCH, OUT, DONE.
- IDLE:
  - `start` -> FETCH; `row_idx` <= 0.
- FETCH:
  - `rom_rd_en` = 1, `rom_addr` = `row_idx`.
  - Next state is always OUT.
- OUT:
  - `row_valid` = 1, `row_data` = `rom_data`.
  - A handshake occurs when `row_valid & row_ready`.
  - Handshake with `row_last` = 0: `rom_rd_en` = 1 and `rom_addr` = `row_idx+1` in the same cycle, `row_idx` increments, and the FSM stays in OUT.
  - Handshake with `row_last` = 1 -> DONE.
  - No handshake: hold. `rom_rd_en` = 0, so the ROM holds its data and `row_data` stays stable.
- DONE:
  - `done` = 1 for one cycle, then -> IDLE.
- `rom_addr` outside an active read is driven to `row_idx` (don't-care to the ROM).
- `abort` in FETCH, OUT or DONE:
  - The FSM goes to IDLE on the next edge and `row_idx` <= 0.
  - `abort` takes priority over a handshake in the same cycle; `done` is not pulsed.
  - `abort` in IDLE has no effect.
- `start` while `busy` is ignored.
- `start` in the same cycle as `done` is ignored, because the state is DONE, not IDLE.
- When `ROWS` = 1, `row_last` is high on the first row.
- Rows are delivered in strict order 0..ROWS-1; each row is delivered exactly once per pass.

## Timing
- Reset values: state IDLE, `row_idx` 0. All outputs are 0: `busy`, `done`, `rom_rd_en`, `rom_addr`, `row_valid`, `row_last` and `kernel_sum`.
- `start` at cycle T: FETCH in T+1, first `row_valid` in T+2.
- With `row_ready` held high: row k is valid in cycle T+2+k. The last row is in T+ROWS+1 and `done` is in T+ROWS+2. A full pass of 11 rows therefore takes 13 cycles from `start` to `done`.
- Each cycle with `row_ready` low adds exactly one cycle of latency.
- Reset asserted mid-pass clears everything asynchronously. After reset is released, no output activity occurs until the next `start`.

## Configuration
- `KSEQ_SUM_EN` defined:
  - `kernel_sum` is cleared when `start` is accepted.
  - On each handshake, `kernel_sum` accumulates the sum of the DW/8 unsigned bytes of `row_data`.
  - The result is final and stable from the `done` cycle until the next accepted `start`.
  - 16-bit width; wraps modulo 2^16.
  - `abort` leaves the partial sum in place.
- `KSEQ_SUM_EN` undefined: the `kernel_sum` port and its adder logic are absent.

## Test plan
- Reset mid-pass: assert `rst` with `row_idx` = 5 in OUT. Required: all outputs 0 at once, IDLE after release, no `rom_rd_en` until `start`.
- Full pass with production ROM contents, `row_ready` held at 1, `start` at cycle 10:
  - Required: `row_valid` in cycles 12..22 with `row_idx` 0..10.
  - Row 5 is `0x040910171e201e17100904`; `row_last` is high only in cycle 22; `done` is high in cycle 23.
  - With `KSEQ_SUM_EN`: `kernel_sum` = 1172.
- Backpressure: `row_ready` follows the pattern 1,0,0,1 repeating. Required: `row_data` and `row_idx` are stable during every stall, no row is skipped or duplicated, and `rom_rd_en` pulses exactly 11 times.
- Abort: assert `abort` in the same cycle as the handshake of row 3. Required: IDLE next cycle, no `done`. A subsequent `start` restarts the pass at row 0.
- Ignored start: pulse `start` while in OUT and again in the DONE cycle. Required: no effect, exactly one `done` per accepted `start`.

Source files
------------

// File: rtl/kernel_row_sequencer.sv
// -----------------------------------------------------------------------------
// kernel_row_sequencer
//
// Walks the Gaussian kernel ROM one row at a time and streams every row to the
// convolution datapath. The block owns the ROM read port and hides the ROM's
// one-cycle registered read latency: a row is fetched one cycle ahead, so with
// the consumer always ready a new row is presented every cycle.
//
// Optional feature macro: KSEQ_SUM_EN
//   When defined, a 16-bit running sum of all weight bytes accepted in the
//   current pass is kept and exposed on kernel_sum.
//
// Parameters
//   ROWS : kernel rows per pass (1..127)
//   AW   : ROM address width
//   DW   : row width in bits, one byte per weight (multiple of 8)
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   begin a pass (only honoured in IDLE)
//   abort      in   terminate a pass in progress, no done pulse
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse after the last row is accepted
//   rom_rd_en  out  ROM read enable
//   rom_addr   out  ROM row address
//   rom_data   in   ROM data, valid the cycle after rom_rd_en, held otherwise
//   row_valid  out  row_data/row_idx/row_last are valid
//   row_ready  in   consumer accepts the current row
//   row_data   out  current kernel row (straight from rom_data)
//   row_idx    out  index of the current row
//   row_last   out  current row is the final row of the pass
//   kernel_sum out  sum of all accepted weights (KSEQ_SUM_EN only)
//
// Handshake: a row transfers on every rising edge where row_valid and
// row_ready are both high. row_valid never drops and row_data/row_idx never
// change while a row is waiting for row_ready.
// -----------------------------------------------------------------------------
module kernel_row_sequencer #(
   parameter int ROWS = 11,
   parameter int AW   = 7,
   parameter int DW   = 88
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          rom_rd_en,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          row_valid,
   input  logic          row_ready,
   output logic [DW-1:0] row_data,
   output logic [6:0]    row_idx,
`ifdef KSEQ_SUM_EN
   output logic [15:0]   kernel_sum,
`endif
   output logic          row_last
);

   // FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_OUT   = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [6:0] LAST_IDX = 7'(ROWS - 1);

   logic [1:0] state_q, state_d;
   logic [6:0] row_idx_q, row_idx_d;
   logic       handshake;

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      row_idx_d = row_idx_q;
      busy      = (state_q != S_IDLE);
      done      = 1'b0;
      rom_rd_en = 1'b0;
      // Outside an active read the address simply mirrors the row index.
      rom_addr  = AW'(row_idx_q);
      row_valid = (state_q == S_OUT);
      row_last  = row_valid && (row_idx_q == LAST_IDX);
      handshake = row_valid && row_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_FETCH;
               row_idx_d = 7'd0;
            end
         end

         S_FETCH: begin
            // Prime the ROM with row 0; its data appears in the OUT cycle.
            rom_rd_en = 1'b1;
            if (abort) begin
               state_d   = S_IDLE;
               row_idx_d = 7'd0;
            end else begin
               state_d   = S_OUT;
            end
         end

         S_OUT: begin
            if (abort) begin
               // Abort wins over a same-cycle handshake: no prefetch, no done.
               state_d   = S_IDLE;
               row_idx_d = 7'd0;
            end else if (handshake) begin
               if (row_last) begin
                  state_d = S_DONE;
               end else begin
                  // Prefetch the next row in the accepting cycle so it is
                  // ready on the very next edge (one row per cycle).
                  rom_rd_en = 1'b1;
                  rom_addr  = AW'(row_idx_q + 7'd1);
                  row_idx_d = row_idx_q + 7'd1;
               end
            end
            // Stall: rom_rd_en stays low, so the ROM holds row_data stable.
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
            if (abort) begin
               row_idx_d = 7'd0;
            end
         end

         default: begin
            state_d   = S_IDLE;
            row_idx_d = 7'd0;
         end
      endcase
   end

   assign row_data = rom_data;
   assign row_idx  = row_idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         row_idx_q <= 7'd0;
      end else begin
         state_q   <= state_d;
         row_idx_q <= row_idx_d;
      end
   end

`ifdef KSEQ_SUM_EN
   // ------------------------------------------------------------------------
   // Weight accumulator
   // ------------------------------------------------------------------------
   logic [15:0] sum_q, sum_d;

   // Unsigned sum of all weight bytes of one row, modulo 2^16.
   function automatic logic [15:0] row_byte_sum(input logic [DW-1:0] row);
      logic [15:0] acc;
      acc = 16'd0;
      for (int i = 0; i < DW / 8; i++) begin
         acc = acc + 16'(row[i*8 +: 8]);
      end
      return acc;
   endfunction

   always_comb begin
      sum_d = sum_q;
      if ((state_q == S_IDLE) && start) begin
         sum_d = 16'd0;
      end else if (handshake && !abort) begin
         // Aborted passes keep their partial sum; the aborting cycle adds nothing.
         sum_d = sum_q + row_byte_sum(rom_data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q <= 16'd0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign kernel_sum = sum_q;
`endif

endmodule

// File: tb/tb_kernel_row_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kernel_row_sequencer
//
// Bench for kernel_row_sequencer with a registered ROM model. The reference
// model is a queue of rows still owed to the consumer plus a fetch-warmup flag
// and a done-pending flag; expected outputs are derived from it every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_kernel_row_sequencer;
   localparam int ROWS = 11;
   localparam int AW   = 7;
   localparam int DW   = 88;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          row_ready = 1'b0;
   logic          busy, done, rom_rd_en, row_valid, row_last;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic [DW-1:0] row_data;
   logic [6:0]    row_idx;
`ifdef KSEQ_SUM_EN
   logic [15:0]   kernel_sum;
`endif

   always #5 clk = ~clk;

   kernel_row_sequencer #(.ROWS(ROWS), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .rom_rd_en  (rom_rd_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .row_data   (row_data),
      .row_idx    (row_idx),
`ifdef KSEQ_SUM_EN
      .kernel_sum (kernel_sum),
`endif
      .row_last   (row_last)
   );

   // ---------------- ROM model (production contents) ----------------
   logic [DW-1:0] rom_mem [ROWS];
   initial begin
      rom_mem[0]  = 88'h0102030406070604030201;
      rom_mem[1]  = 88'h0102040507070705040201;
      rom_mem[2]  = 88'h0204070a0d0e0d0a070402;
      rom_mem[3]  = 88'h03060b10141614100b0603;
      rom_mem[4]  = 88'h04080f161c1e1c160f0804;
      rom_mem[5]  = 88'h040910171e201e17100904;
      rom_mem[6]  = 88'h04080f161c1e1c160f0804;
      rom_mem[7]  = 88'h03060b10141614100b0603;
      rom_mem[8]  = 88'h0204070a0d0e0d0a070402;
      rom_mem[9]  = 88'h0102040507070705040201;
      rom_mem[10] = 88'h0102030406070604030201;
   end

   always @(posedge clk) begin
      if (rom_rd_en) begin
         rom_data <= (int'(rom_addr) < ROWS) ? rom_mem[int'(rom_addr)] : '0;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- check helper ----------------
   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [127:0] act,
                                 input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int row_sum(input logic [DW-1:0] r);
      int s = 0;
      for (int i = 0; i < DW / 8; i++) s += int'(r[i*8 +: 8]);
      return s;
   endfunction

   // ---------------- reference model + scoreboard ----------------
   int          exp_q[$];      // row indices still owed in this pass, in order
   bit          m_warm = 0;    // the pass's initial ROM fetch cycle
   bit          m_done = 0;    // done pulse owed this cycle
   logic [15:0] m_sum = '0;

   int          done_cnt = 0, rd_cnt = 0, last_cnt = 0;
   int          first_valid_cyc = -1, first_valid_idx = -1;
   int          last_cyc = -1, done_cyc = -1;
   logic [DW-1:0] row5_data = '0;
   bit          prev_stall = 0;
   logic [6:0]  prev_idx = '0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      bit e_busy, e_valid, e_rd, e_last;
      int e_idx;
      if (rst) begin
         exp_q.delete();
         m_warm = 0;
         m_done = 0;
         m_sum  = '0;
         check("rst_addr", 128'(rom_addr), 128'd0);
         check("rst_idx", 128'(row_idx), 128'd0);
      end
      e_busy  = m_warm || (exp_q.size() > 0) || m_done;
      e_valid = !m_warm && (exp_q.size() > 0);
      e_idx   = e_valid ? exp_q[0] : 0;
      e_last  = e_valid && (e_idx == ROWS - 1);
      e_rd    = m_warm || (e_valid && row_ready && !abort && exp_q.size() > 1);

      check("busy", 128'(busy), 128'(e_busy));
      check("done", 128'(done), 128'(m_done));
      check("row_valid", 128'(row_valid), 128'(e_valid));
      check("row_last", 128'(row_last), 128'(e_last));
      check("rom_rd_en", 128'(rom_rd_en), 128'(e_rd));
      if (e_rd) check("rom_addr", 128'(rom_addr), 128'(m_warm ? 0 : e_idx + 1));
      if (e_valid) begin
         check("row_idx", 128'(row_idx), 128'(e_idx));
         check("row_data", 128'(row_data), 128'(rom_mem[e_idx]));
      end
`ifdef KSEQ_SUM_EN
      check("kernel_sum", 128'(kernel_sum), 128'(m_sum));
`endif
      if (prev_stall && !rst) begin
         check("stall_idx", 128'(row_idx), 128'(prev_idx));
         check("stall_data", 128'(row_data), 128'(prev_data));
      end

      // event recorders for the directed tests
      if (row_valid && first_valid_cyc < 0) begin
         first_valid_cyc = cyc;
         first_valid_idx = int'(row_idx);
      end
      if (row_last) begin last_cyc = cyc; last_cnt++; end
      if (done) begin done_cyc = cyc; done_cnt++; end
      if (rom_rd_en) rd_cnt++;
      if (row_valid && row_idx == 7'd5) row5_data = row_data;
      prev_stall = row_valid && !row_ready && !abort && !rst;
      prev_idx   = row_idx;
      prev_data  = row_data;

      // advance the model with the inputs sampled at the coming edge
      if (!rst) begin
         if (!e_busy) begin
            if (start) begin
               m_warm = 1;
               exp_q.delete();
               for (int k = 0; k < ROWS; k++) exp_q.push_back(k);
               m_sum = '0;
            end
         end else if (abort) begin
            m_warm = 0;
            m_done = 0;
            exp_q.delete();
         end else if (m_warm) begin
            m_warm = 0;
         end else if (m_done) begin
            m_done = 0;
         end else if (row_ready) begin
            m_sum = m_sum + 16'(row_sum(rom_mem[exp_q[0]]));
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1;
         end
      end
   end

   // ---------------- ready driver ----------------
   int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0,1, 2: random
   int pat = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       row_ready = 1'b1;
            1:       row_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
            default: row_ready = 1'($urandom_range(0, 1));
         endcase
         pat++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin tick(); n++; end
      check({tag, "_done_seen"}, 128'(done), 128'd1);
      tick();
   endtask

   task automatic wait_row(input string tag, input int idx, input int budget);
      int n = 0;
      while (!(row_valid === 1'b1 && int'(row_idx) == idx) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_row_seen"}, 128'(row_valid && int'(row_idx) == idx), 128'd1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin tick(); n++; end
      check("idle_reached", 128'(busy), 128'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0, r0;
      #1 rst = 1'b1;
      #1;
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_rd_en", 128'(rom_rd_en), 128'd0);
      check("reset_valid", 128'(row_valid), 128'd0);
      while (cyc < 3) tick();
      rst = 1'b0;

      // Full pass, ready held high, start in cycle 10.
      ready_mode = 0;
      while (cyc < 10) tick();
      first_valid_cyc = -1;
      last_cnt = 0;
      d0 = done_cnt;
      pulse_start();
      wait_done("full", 40);
      check("full_first_valid_cyc", 128'(first_valid_cyc), 128'd12);
      check("full_first_idx", 128'(first_valid_idx), 128'd0);
      check("full_last_cyc", 128'(last_cyc), 128'd22);
      check("full_last_count", 128'(last_cnt), 128'd1);
      check("full_done_cyc", 128'(done_cyc), 128'd23);
      check("full_done_count", 128'(done_cnt - d0), 128'd1);
      check("full_row5", 128'(row5_data), 128'(88'h040910171e201e17100904));
`ifdef KSEQ_SUM_EN
      check("full_kernel_sum", 128'(kernel_sum), 128'd1172);
`endif
      wait_idle(10);

      // Backpressure 1,0,0,1.
      ready_mode = 1;
      pat = 0;
      r0 = rd_cnt;
      d0 = done_cnt;
      pulse_start();
      wait_done("bp", 80);
      check("bp_rd_en_pulses", 128'(rd_cnt - r0), 128'd11);
      check("bp_done_count", 128'(done_cnt - d0), 128'd1);
      wait_idle(10);

      // Abort on the handshake of row 3, then restart.
      ready_mode = 0;
      d0 = done_cnt;
      pulse_start();
      wait_row("abort", 3, 20);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_idle_next", 128'(busy), 128'd0);
      repeat (4) tick();
      check("abort_no_done", 128'(done_cnt - d0), 128'd0);
      first_valid_cyc = -1;
      pulse_start();
      wait_done("restart", 40);
      check("restart_first_idx", 128'(first_valid_idx), 128'd0);
      check("restart_done_count", 128'(done_cnt - d0), 128'd1);
      wait_idle(10);

      // Start pulses while in OUT and in the DONE cycle are ignored.
      ready_mode = 1;
      d0 = done_cnt;
      pulse_start();
      wait_row("ign", 2, 20);
      pulse_start();
      begin
         int n = 0;
         while (done !== 1'b1 && n < 80) begin tick(); n++; end
         check("ign_done_seen", 128'(done), 128'd1);
      end
      pulse_start();
      repeat (4) tick();
      check("ign_idle_after", 128'(busy), 128'd0);
      check("ign_done_count", 128'(done_cnt - d0), 128'd1);

      // Reset in the middle of a pass, with row 5 presented.
      ready_mode = 0;
      pulse_start();
      wait_row("rstmid", 5, 20);
      #1 rst = 1'b1;
      #1;
      check("rstmid_busy", 128'(busy), 128'd0);
      check("rstmid_valid", 128'(row_valid), 128'd0);
      check("rstmid_rd_en", 128'(rom_rd_en), 128'd0);
      check("rstmid_idx", 128'(row_idx), 128'd0);
      tick();
      tick();
      rst = 1'b0;
      r0 = rd_cnt;
      repeat (10) tick();
      check("rstmid_no_rd_en", 128'(rd_cnt - r0), 128'd0);
      check("rstmid_idle", 128'(busy), 128'd0);
      d0 = done_cnt;
      pulse_start();
      wait_done("rstmid_pass", 40);
      check("rstmid_pass_done", 128'(done_cnt - d0), 128'd1);

      // Random traffic: random ready, starts and occasional aborts.
      ready_mode = 2;
      for (int i = 0; i < 1500; i++) begin
         start = ($urandom_range(0, 7) == 0);
         abort = ($urandom_range(0, 40) == 0);
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      ready_mode = 0;
      wait_idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
